// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE X-path load sequencer.
// Holds the feeder FSM encoding, the job configuration bundle and the limit normaliser.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH = 12;
    localparam int unsigned DATA_W      = 288;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_FILL,
        XF_DRAIN,
        XF_DONE
    } x_feeder_state_e;

    // Job limits after normalisation; kept 32-bit so any parameterisation fits.
    typedef struct packed {
        int unsigned n_tiles;
        int unsigned rows_lftovr;
    } x_feeder_cfg_t;

    // A programmed zero selects the natural default (1 tile, or a full tile of rows).
    function automatic int unsigned xf_norm(input int unsigned v, input int unsigned dflt);
        return (v == 0) ? dflt : v;
    endfunction

endpackage

// File: rtl/redmule_x_feeder_fifo.sv
// Two-entry DW-wide FIFO between the memory streamer and the X buffer.
// A push into an empty FIFO becomes visible at the head on the following cycle.
module redmule_x_feeder_fifo #(
    parameter int unsigned DW = 288
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] cnt_reg;
    logic       push_eff;
    logic       pop_eff;

    assign full_o   = (cnt_reg == 2'd2);
    assign empty_o  = (cnt_reg == 2'd0);
    assign push_eff = push_i && !full_o && !flush_i;
    assign pop_eff  = pop_i && !empty_o && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DW-1:0] entry_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    entry_reg <= '0;
                end else if (push_eff && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= data_i;
                end
            end
        end
    endgenerate

    assign data_o = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop_eff) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            cnt_reg <= cnt_reg + {1'b0, push_eff} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/redmule_x_feeder.sv
// Load sequencer for the RedMulE X buffer: buffers streamer rows and fills the
// X buffer one tile at a time, waiting for it to drain between tiles.
module redmule_x_feeder
    import redmule_pkg::*;
#(
    parameter  int unsigned DW       = DATA_W,
    parameter  int unsigned Width    = ARRAY_WIDTH,
    parameter  int unsigned TileCntW = 16,
    localparam int unsigned RowCntW  = $clog2(Width) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [TileCntW-1:0] n_tiles_i,
    input  logic [RowCntW-1:0]  rows_lftovr_i,
    input  logic [DW-1:0]       x_data_i,
    input  logic                x_valid_i,
    output logic                x_ready_o,
    output logic [DW-1:0]       x_buffer_o,
    output logic                load_o,
    input  logic                buf_empty_i,
    output logic [TileCntW-1:0] tile_idx_o,
    output logic                busy_o,
    output logic                done_o
);

    x_feeder_state_e     state_reg;
    logic [RowCntW-1:0]  row_cnt_reg;
    logic [RowCntW-1:0]  row_cnt_next;
    logic [RowCntW-1:0]  lim_last_reg;
    logic [RowCntW-1:0]  row_lim;
    logic [TileCntW-1:0] tile_idx_reg;
    logic [TileCntW-1:0] tiles_reg;
    logic                last_tile;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    x_feeder_cfg_t       start_cfg;

    assign start_cfg.n_tiles     = xf_norm(32'(n_tiles_i), 1);
    assign start_cfg.rows_lftovr = xf_norm(32'(rows_lftovr_i), Width);

    assign last_tile    = (tile_idx_reg == tiles_reg - TileCntW'(1));
    assign row_lim      = last_tile ? lim_last_reg : RowCntW'(Width);
    assign row_cnt_next = row_cnt_reg + RowCntW'(1);

    // Loads depend only on registered state, so the X buffer sees a glitch-free strobe.
    assign pop        = (state_reg == XF_FILL) && !fifo_empty;
    assign load_o     = pop;
    assign x_ready_o  = !fifo_full;
    assign busy_o     = (state_reg != XF_IDLE);
    assign done_o     = (state_reg == XF_DONE);
    assign tile_idx_o = tile_idx_reg;

    redmule_x_feeder_fifo #(
        .DW (DW)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (x_valid_i),
        .data_i  (x_data_i),
        .pop_i   (pop),
        .data_o  (x_buffer_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= XF_IDLE;
            row_cnt_reg  <= '0;
            tile_idx_reg <= '0;
            tiles_reg    <= TileCntW'(1);
            lim_last_reg <= RowCntW'(Width);
        end else if (clear_i) begin
            state_reg    <= XF_IDLE;
            row_cnt_reg  <= '0;
            tile_idx_reg <= '0;
            tiles_reg    <= TileCntW'(1);
            lim_last_reg <= RowCntW'(Width);
        end else begin
            case (state_reg)
                XF_IDLE: begin
                    if (start_i) begin
                        tiles_reg    <= TileCntW'(start_cfg.n_tiles);
                        lim_last_reg <= RowCntW'(start_cfg.rows_lftovr);
                        row_cnt_reg  <= '0;
                        tile_idx_reg <= '0;
                        state_reg    <= XF_FILL;
                    end
                end
                XF_FILL: begin
                    if (pop) begin
                        if (row_cnt_next == row_lim) begin
                            row_cnt_reg <= '0;
                            state_reg   <= XF_DRAIN;
                        end else begin
                            row_cnt_reg <= row_cnt_next;
                        end
                    end
                end
                XF_DRAIN: begin
                    if (buf_empty_i) begin
                        if (last_tile) begin
                            state_reg <= XF_DONE;
                        end else begin
                            tile_idx_reg <= tile_idx_reg + TileCntW'(1);
                            state_reg    <= XF_FILL;
                        end
                    end
                end
                XF_DONE: begin
                    state_reg <= XF_IDLE;
                end
                default: begin
                    state_reg <= XF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_x_feeder.sv
// Directed-plus-random bench for redmule_x_feeder; a row queue models the FIFO
// and per-job arithmetic gives the expected load counts per tile.
module tb_redmule_x_feeder;

    localparam int DW = 288;
    localparam int W  = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   n_tiles_i = '0;
    logic [4:0]    rows_lftovr_i = '0;
    logic [DW-1:0] x_data_i = '0;
    logic          x_valid_i = 1'b0;
    logic          x_ready_o;
    logic [DW-1:0] x_buffer_o;
    logic          load_o;
    logic          buf_empty_i = 1'b0;
    logic [15:0]   tile_idx_o;
    logic          busy_o;
    logic          done_o;

    redmule_x_feeder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .n_tiles_i     (n_tiles_i),
        .rows_lftovr_i (rows_lftovr_i),
        .x_data_i      (x_data_i),
        .x_valid_i     (x_valid_i),
        .x_ready_o     (x_ready_o),
        .x_buffer_o    (x_buffer_o),
        .load_o        (load_o),
        .buf_empty_i   (buf_empty_i),
        .tile_idx_o    (tile_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            nloads = 0;
    int            ndone = 0;
    int            mode = 0;   // 0 idle, 1 continuous, 2 toggling, 3 random valid
    int            load_cyc[$];
    logic [DW-1:0] q[$];

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the streamer after the rising edge.
    task automatic tick();
        logic [DW-1:0] exp;
        @(negedge clk_i);
        if (clear_i) begin
            q.delete();
        end else begin
            if (load_o) begin
                exp = (q.size() > 0) ? q[0] : {DW{1'bx}};
                check_data("load_data", x_buffer_o, exp);
                if (q.size() > 0) void'(q.pop_front());
                load_cyc.push_back(cyc);
                nloads++;
            end
            if (x_valid_i && x_ready_o) q.push_back(x_data_i);
        end
        if (done_o) ndone++;
        @(posedge clk_i);
        #1;
        cyc++;
        case (mode)
            1:       x_valid_i = 1'b1;
            2:       x_valid_i = !x_valid_i;
            3:       x_valid_i = ($urandom_range(0, 1) == 1);
            default: x_valid_i = 1'b0;
        endcase
        x_data_i = rand_row();
    endtask

    task automatic wait_loads(input int target);
        for (int k = 0; k < 400 && nloads < target; k++) tick();
    endtask

    task automatic run_job(input int n, input int lr, input int md, input int dw, input bit poke);
        int tiles;
        int last;
        int lim;
        int base;
        int dbase;
        int target;
        int cyc_start;
        bit prefilled;
        tiles = (n == 0) ? 1 : n;
        last  = (lr == 0) ? W : lr;
        base  = nloads;
        dbase = ndone;
        mode  = md;
        prefilled = (q.size() > 0);
        n_tiles_i     = 16'(n);
        rows_lftovr_i = 5'(lr);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc_start = cyc;
        n_tiles_i     = 16'($urandom_range(0, 9));
        rows_lftovr_i = 5'($urandom_range(0, W));
        check_int("busy_after_start", int'(busy_o), 1);
        target = base;
        for (int t = 0; t < tiles; t++) begin
            lim = (t == tiles - 1) ? last : W;
            target += lim;
            for (int k = 0; k < 400 && nloads < target; k++) begin
                if (poke && t == 0 && k == 3) begin
                    start_i = 1'b1;
                    n_tiles_i = 16'd7;
                end
                tick();
                start_i = 1'b0;
            end
            check_int($sformatf("tile%0d_loads", t), nloads - base, target - base);
            check_int($sformatf("tile%0d_idx", t), int'(tile_idx_o), t);
            if (md == 1 && t == 0 && prefilled)
                check_int("first_load_latency", load_cyc[base], cyc_start);
            if (md == 1 && nloads == target)
                check_int($sformatf("tile%0d_consecutive", t),
                          load_cyc[target-1] - load_cyc[target-lim], lim - 1);
            for (int k = 0; k < dw; k++) tick();
            check_int($sformatf("drain%0d_no_load", t), nloads - base, target - base);
            check_int("drain_load_low", int'(load_o), 0);
            if (md == 1 && dw >= 3) check_int("drain_fifo_full", int'(x_ready_o), 0);
            buf_empty_i = 1'b1;
            tick();
            buf_empty_i = 1'b0;
            if (t == tiles - 1) begin
                check_int("done_pulse", int'(done_o), 1);
                tick();
                check_int("done_clear", int'(done_o), 0);
                check_int("idle_after_done", int'(busy_o), 0);
                check_int("done_count", ndone - dbase, 1);
            end else begin
                check_int("next_tile_idx", int'(tile_idx_o), t + 1);
                check_int("busy_between", int'(busy_o), 1);
            end
        end
        $display("job n_tiles=%0d lftovr=%0d mode=%0d loads=%0d", n, lr, md, nloads - base);
    endtask

    initial begin
        int base;
        int dbase;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_int("rst_ready", int'(x_ready_o), 1);
        check_int("rst_load", int'(load_o), 0);
        check_int("rst_busy", int'(busy_o), 0);
        check_int("rst_done", int'(done_o), 0);
        check_int("rst_tile_idx", int'(tile_idx_o), 0);
        check_data("rst_xbuf", x_buffer_o, '0);
        $display("reset checked");

        // Prefetch while idle: FIFO fills, nothing is loaded.
        mode = 1;
        repeat (4) tick();
        check_int("prefill_ready", int'(x_ready_o), 0);
        check_int("prefill_no_load", int'(load_o), 0);
        check_int("prefill_idle", int'(busy_o), 0);
        $display("prefill checked");

        run_job(1, 0, 1, 4, 1'b0);
        run_job(3, 5, 1, 3, 1'b0);
        run_job(2, 0, 1, 20, 1'b0);
        run_job(1, 0, 2, 4, 1'b0);

        // Clear in the middle of the second tile.
        mode  = 1;
        base  = nloads;
        dbase = ndone;
        n_tiles_i = 16'd2;
        rows_lftovr_i = 5'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_loads(base + W);
        repeat (2) tick();
        buf_empty_i = 1'b1;
        tick();
        buf_empty_i = 1'b0;
        check_int("clr_pre_tile_idx", int'(tile_idx_o), 1);
        wait_loads(base + W + 7);
        check_int("clr_pre_loads", nloads - base, W + 7);
        clear_i = 1'b1;
        mode = 0;
        tick();
        clear_i = 1'b0;
        check_int("clr_busy", int'(busy_o), 0);
        check_int("clr_tile_idx", int'(tile_idx_o), 0);
        check_int("clr_ready", int'(x_ready_o), 1);
        check_int("clr_load", int'(load_o), 0);
        repeat (3) tick();
        check_int("clr_no_done", ndone - dbase, 0);
        check_int("clr_fifo_empty", int'(load_o), 0);
        $display("clear checked loads_before=%0d", nloads - base);

        run_job(1, 0, 1, 3, 1'b0);
        run_job(0, 0, 1, 3, 1'b0);
        run_job(2, 0, 1, 3, 1'b1);
        run_job(2, 1, 3, 4, 1'b0);

        mode = 0;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redmule_x_feeder.md
# redmule_x_feeder

Upstream load sequencer for the RedMulE X buffer. It accepts DW-bit X rows from the memory streamer over a valid/ready stream, holds them in a 2-entry FIFO, and issues one `load` strobe per row to the X buffer. Each tile is W rows, or `rows_lftovr_i` rows on the last tile. After a tile is filled, the feeder waits for the X buffer to report drain before filling the next one, and it signals completion after the programmed number of tiles.

## Interface

Parameters:
- `DW`, default 288: stream and X-buffer input width.
- `Width`, default `ARRAY_WIDTH`: W, rows per full tile.
- `TileCntW`, default 16: width of the tile counter.

Ports (clock and reset are `clk_i` and `rst_ni`, with one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous soft clear, same effect as reset.
- `start_i` in 1: start pulse, sampled only in IDLE.
- `n_tiles_i` in TileCntW: tiles per job; 0 is treated as 1.
- `rows_lftovr_i` in $clog2(W)+1: rows in the last tile; 0 means W.
- `x_data_i` in DW: streamer row data.
- `x_valid_i` in 1: streamer valid.
- `x_ready_o` out 1: FIFO not full.
- `x_buffer_o` out DW: FIFO head, wired to the X buffer data input.
- `load_o` out 1: X-buffer load strobe.
- `buf_empty_i` in 1: X-buffer empty flag (drain complete).
- `tile_idx_o` out TileCntW: index of the tile currently being filled.
- `busy_o` out 1: asserted when the FSM is not in IDLE.
- `done_o` out 1: one-cycle pulse when the last tile has drained.

## Operation

FIFO:
- 2 entries, so full throughput is 1 row/cycle.
- Push occurs when `x_valid_i && x_ready_o`.
- Pop occurs when `load_o`.
- `x_ready_o = !full`. The FIFO accepts rows in any state, including prefetch during IDLE and DRAIN.
- A simultaneous push and pop when full is not allowed, because ready is low. When the FIFO is empty, a push in the same cycle is not visible at the head until the next cycle.

FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - On `start_i`, latch the limits: `tiles = max(n_tiles_i, 1)` and `lim_last = (rows_lftovr_i == 0) ? W : rows_lftovr_i`.
  - Clear `row_cnt` and `tile_idx`, then go to FILL.
- FILL:
  - `load_o = fifo_nonempty`.
  - Each load increments `row_cnt`.
  - The row limit is `lim_last` when `tile_idx == tiles-1`, otherwise W.
  - When a load brings `row_cnt+1` to the limit, reset `row_cnt` to 0 and go to DRAIN.
- DRAIN:
  - No loads are issued.
  - On `buf_empty_i`:
    - If `tile_idx == tiles-1`, go to DONE.
    - Otherwise increment `tile_idx` and go to FILL.
- DONE: assert `done_o` for 1 cycle, then go to IDLE.

Rules and corner cases:
- `start_i` outside IDLE is ignored.
- Configuration changes during a job are ignored, because the limits are latched at start.
- Rows remaining in the FIFO at the end of a job are kept for the next job; they are not flushed.
- `clear_i` or reset mid-job does the following:
  - FSM goes to IDLE.
  - Counters go to 0.
  - FIFO is emptied.
  - `done_o` is not asserted.
  - `clear_i` has priority over all other events in the same cycle.
- Counter width: `row_cnt` is $clog2(W)+1 bits, so it never wraps. `tile_idx` wraps only past `2^TileCntW-1`, which is unreachable because `tiles` is at most that value.

## Timing

- Reset values of all outputs:
  - `x_ready_o = 1`
  - `load_o = 0`
  - `busy_o = 0`
  - `done_o = 0`
  - `tile_idx_o = 0`
  - `x_buffer_o = 0`
- `load_o` and `x_buffer_o` are driven combinationally from FIFO state registers and FSM state registers. There is no combinational path from any input to them.
- The X buffer samples `x_buffer_o` on the same edge on which the feeder pops.
- Latency and throughput:
  - Minimum start-to-first-load is 1 cycle (`start_i` at edge N, FILL at N+1), provided the FIFO was prefilled.
  - Streamer-to-load latency is 1 cycle.
  - In FILL with continuous valid, throughput is W loads in W consecutive cycles.
- `buf_empty_i` is acted upon in DRAIN only; it is ignored in FILL.
- `done_o` is asserted in the cycle after the final `buf_empty_i` is seen in DRAIN.

## Structure

- The FSM state enum belongs in `redmule_pkg` as `x_feeder_state_e`.
- A `x_feeder_cfg_t` struct in `redmule_pkg` bundles `n_tiles` and `rows_lftovr`.
- One sub-module: `redmule_x_feeder_fifo`, a 2-entry DW-wide FIFO with push/pop, full/empty flags and flush.

## Test plan

- Single full tile, W=12, `n_tiles_i=1`, `rows_lftovr_i=0`, continuous valid:
  - Exactly 12 `load_o` pulses on consecutive cycles, with data in order.
  - Then DRAIN; `buf_empty_i` pulse → `done_o` pulse 1 cycle later.
- Leftover rows, `n_tiles_i=3`, `rows_lftovr_i=5`:
  - Load counts are 12, 12, 5.
  - `tile_idx_o` steps 0→1→2.
  - Exactly 1 `done_o` pulse.
- Backpressure:
  - Hold `buf_empty_i=0` in DRAIN for 20 cycles while the streamer is valid.
  - FIFO fills after 2 pushes, `x_ready_o=0`, no loads, no data loss.
  - On `buf_empty_i`, the two queued rows load first.
- Bubbly streamer with valid toggling 1/0:
  - `load_o` only with FIFO non-empty.
  - Total 12 loads.
  - Order preserved.
- `clear_i` after 7 loads:
  - Next cycle: `busy_o=0`, `tile_idx_o=0`, `x_ready_o=1`, FIFO empty, no `done_o`.
  - A new start loads 12 fresh rows.
- Edge configuration:
  - `n_tiles_i=0` behaves as 1 tile.
  - `start_i` asserted during FILL is ignored.
  - `rows_lftovr_i=1` gives a last tile of exactly 1 load.
